// File: rtl/prim_ram_1p_march_bist.sv
// March C- built-in self-test initiator for the single-port SRAM primitive.
// Issues one RAM access per cycle over six march elements, checks each read
// one cycle later, and reports the first failing address/bits plus a
// saturating mismatch count.
module prim_ram_1p_march_bist #(
  parameter int Width = 32,
  parameter int Depth = 128,
  localparam int Aw = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             fail_o,
  output logic [Aw-1:0]    fail_addr_o,
  output logic [Width-1:0] fail_bits_o,
  output logic [15:0]      err_cnt_o,
  output logic             req_o,
  output logic             write_o,
  output logic [Aw-1:0]    addr_o,
  output logic [Width-1:0] wdata_o,
  output logic [Width-1:0] wmask_o,
  input  logic [Width-1:0] rdata_i
);

  localparam logic [Aw-1:0] AddrMax = Aw'(Depth - 1);
  localparam logic [Aw-1:0] AddrOne = Aw'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [2:0]    elem_q;   // march element M0..M5
  logic [Aw-1:0] addr_q;
  logic          phase_q;  // 0: first op on this address, 1: second op

  logic          single_op, is_write, desc, op_last, addr_last, elem_last;
  logic          wr_bg, rd_bg, start_acc;

  logic          cmp_valid_q, cmp_exp_q;
  logic [Aw-1:0] cmp_addr_q;
  logic          mismatch;

  // M0 is write-only and M5 is read-only; M1..M4 do read then write.
  assign single_op = (elem_q == 3'd0) || (elem_q == 3'd5);
  assign is_write  = (elem_q == 3'd0) || (!single_op && phase_q);
  assign desc      = (elem_q == 3'd3) || (elem_q == 3'd4);
  assign op_last   = single_op || phase_q;
  assign addr_last = desc ? (addr_q == '0) : (addr_q == AddrMax);
  assign elem_last = (elem_q == 3'd5);
  // Backgrounds: writes of B1 in M1/M3, reads of B1 in M2/M4.
  assign wr_bg     = (elem_q == 3'd1) || (elem_q == 3'd3);
  assign rd_bg     = (elem_q == 3'd2) || (elem_q == 3'd4);
  assign start_acc = (state_q == IDLE) && start_i;

  // Read data is checked against a background registered with the read.
  assign mismatch  = cmp_valid_q && (rdata_i != {Width{cmp_exp_q}});

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic and RAM/status drive.
  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    req_o   = 1'b0;
    write_o = 1'b0;
    addr_o  = '0;
    wdata_o = '0;
    wmask_o = '0;
    case (state_q)
      IDLE: if (start_i) state_d = RUN;
      RUN: begin
        busy_o  = 1'b1;
        req_o   = 1'b1;
        write_o = is_write;
        addr_o  = addr_q;
        if (is_write) begin
          wdata_o = {Width{wr_bg}};
          wmask_o = '1;
        end
        if (op_last && addr_last && elem_last) state_d = DRAIN;
      end
      DRAIN: begin
        busy_o  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // March sequencer: phase, address and element counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      elem_q  <= '0;
      addr_q  <= '0;
      phase_q <= 1'b0;
    end else if (start_acc) begin
      elem_q  <= '0;
      addr_q  <= '0;
      phase_q <= 1'b0;
    end else if (state_q == RUN) begin
      phase_q <= !op_last;
      if (op_last) begin
        if (addr_last) begin
          elem_q <= elem_q + 3'd1;
          // M3 and M4 start from the top address.
          addr_q <= ((elem_q == 3'd2) || (elem_q == 3'd3)) ? AddrMax : '0;
        end else begin
          addr_q <= desc ? (addr_q - AddrOne) : (addr_q + AddrOne);
        end
      end
    end
  end

  // Compare pipeline: remember what each read should return.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmp_valid_q <= 1'b0;
      cmp_exp_q   <= 1'b0;
      cmp_addr_q  <= '0;
    end else begin
      cmp_valid_q <= (state_q == RUN) && !is_write;
      cmp_exp_q   <= rd_bg;
      cmp_addr_q  <= addr_q;
    end
  end

  // Result capture: first failure is sticky, count saturates.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fail_o      <= 1'b0;
      fail_addr_o <= '0;
      fail_bits_o <= '0;
      err_cnt_o   <= '0;
    end else if (start_acc) begin
      fail_o      <= 1'b0;
      fail_addr_o <= '0;
      fail_bits_o <= '0;
      err_cnt_o   <= '0;
    end else if (mismatch) begin
      if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + 16'd1;
      if (!fail_o) begin
        fail_o      <= 1'b1;
        fail_addr_o <= cmp_addr_q;
        fail_bits_o <= {Width{cmp_exp_q}} ^ rdata_i;
      end
    end
  end

endmodule

// File: doc/prim_ram_1p_march_bist.md
Name: prim_ram_1p_march_bist

Overview:
- Built-in self-test initiator for the single-port SRAM primitive: drives the RAM's req/write/addr/wdata/wmask port and consumes its rdata.
- Runs a March C- algorithm over every address and compares each read against the expected background.
- Reports the first failing address and bit pattern, plus a saturating error count.
- Used in DV to prove that injected bad bits are detected, and on silicon as a power-on memory test.

Parameters:
- Width, 32, RAM data width in bits (1..128).
- Depth, 128, number of RAM words (>=2; need not be a power of two).
- Aw, $clog2(Depth), localparam, address width.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- start_i  input  1  start request; sampled only in IDLE.
- busy_o  output  1  test in progress.
- done_o  output  1  one-cycle pulse when the test completes.
- fail_o  output  1  sticky: at least one read mismatch in the last run.
- fail_addr_o  output  Aw  address of the first mismatch.
- fail_bits_o  output  Width  expected XOR actual data at the first mismatch.
- err_cnt_o  output  16  number of mismatching reads, saturating at 16'hFFFF.
- req_o  output  1  RAM request.
- write_o  output  1  RAM write enable, valid when req_o is high.
- addr_o  output  Aw  RAM address.
- wdata_o  output  Width  RAM write data.
- wmask_o  output  Width  RAM write mask.
- rdata_i  input  Width  RAM read data, valid exactly one cycle after a read request.

Behaviour:
- Reset (asynchronous, rst_ni low):
  - FSM goes to IDLE.
  - All outputs are 0, including req_o, write_o, addr_o, wdata_o, wmask_o, fail_*, err_cnt_o.
  - A reset mid-run aborts immediately; no further RAM accesses are made and no done_o pulse is produced.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start_i high clears fail_o, fail_addr_o, fail_bits_o and err_cnt_o, then moves to RUN.
  - The cycle in which start is accepted is cycle 0.
- RUN issues exactly one RAM access per cycle. The elements below run in order, with B0 = all zeros and B1 = all ones:
  - M0: ascending address, w B0.
  - M1: ascending address, r B0 then w B1.
  - M2: ascending address, r B1 then w B0.
  - M3: descending address, r B0 then w B1.
  - M4: descending address, r B1 then w B0.
  - M5: ascending address, r B0.
- Access ordering and counting:
  - Within an element, both operations complete on one address before the address steps.
  - Ascending runs 0..Depth-1; descending runs Depth-1..0.
  - Addresses >= Depth are never driven.
  - Total accesses are 10*Depth, occurring in cycles 1..10*Depth.
- Drive rules:
  - On a write: req_o=1, write_o=1, wmask_o all ones, wdata_o equals the background.
  - On a read: req_o=1, write_o=0, wdata_o=0, wmask_o=0.
  - Outside RUN: req_o=0, write_o=0, addr_o=0.
- Compare pipeline:
  - Each read registers cmp_valid, the expected background and the address.
  - In the next cycle rdata_i is compared against the expected value.
  - On mismatch: err_cnt_o increments (saturating).
  - If fail_o was 0, the first mismatch also sets fail_o=1 and captures fail_addr_o and fail_bits_o (expected ^ rdata_i).
  - Later mismatches never overwrite the captured address or bits.
- After the last access (cycle 10*Depth) the FSM enters DRAIN for one cycle (cycle 10*Depth+1), which performs the final compare.
- DONE:
  - Occurs in cycle 10*Depth+2.
  - done_o=1 for exactly that cycle; the FSM then returns to IDLE.
- busy_o is 1 in RUN and DRAIN (cycles 1..10*Depth+1) and 0 otherwise.
- Result outputs are stable from DONE until the next accepted start.
- start_i outside IDLE (including during DONE) is ignored and never queued.
- rdata_i is ignored in every cycle that does not follow a read.

Test Plan:
- Fault-free run, Width=8, Depth=8, model RAM with 1-cycle read latency, start pulse in cycle 0 -> 80 accesses in cycles 1..80, done_o only in cycle 82, busy_o high in cycles 1..81, fail_o=0, err_cnt_o=0; the write/read sequence matches the March C- ordering above exactly.
- Bit 3 flipped on every read of address 5 (Width=8, Depth=8) -> fail_o=1, fail_addr_o=5, fail_bits_o=8'h08, err_cnt_o=5.
- Bit 0 flipped on every read of every address -> fail_addr_o=0 (first M1 read), fail_bits_o=8'h01, err_cnt_o=40.
- Second start after a failing run, RAM now clean -> fail_o, fail_bits_o and err_cnt_o cleared in cycle 1; final fail_o=0, err_cnt_o=0.
- start_i held high through a whole run, Depth=6 -> accesses in cycles 1..60 only, addr_o never 6 or 7, done_o in cycle 62, new run starts in IDLE cycle 63 (first req_o in cycle 64).
- rst_ni low in cycle 30 -> req_o=0 in the same cycle (asynchronous), busy_o=0, no done_o; a subsequent start runs a full 80-access test.
